// File: rtl/wfg_sample_streamer.sv
// Read-side sequencer for the waveform sample RAM: walks an address window, hides the
// one-cycle read latency in a 2-entry buffer and streams samples out. Macro WFG_STREAMER_LOOP_EN enables looping.
module wfg_sample_streamer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic [ADDR_WIDTH-1:0] start_addr,
   input  logic [ADDR_WIDTH-1:0] end_addr,
   output logic                  ram_csb,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   input  logic [DATA_WIDTH-1:0] ram_dout,
   output logic [DATA_WIDTH-1:0] sample_o,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic                  busy_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [ADDR_WIDTH-1:0] r_end;
`ifdef WFG_STREAMER_LOOP_EN
   logic [ADDR_WIDTH-1:0] r_start;
`endif
   logic                  r_inflight;
   logic                  r_busy;
   logic                  r_done;
   logic [1:0]            r_count;
   logic [DATA_WIDTH-1:0] r_buf0;
   logic [DATA_WIDTH-1:0] r_buf1;

   logic                  w_pop;
   logic                  w_issue;
   logic                  w_abort;
   logic [2:0]            w_level;

   // Issue only when the words already owed downstream leave room in the buffer
   always_comb begin
      w_pop   = (r_count != 2'd0) && ready_i;
      w_level = {1'b0, r_count} - {2'b00, w_pop} + {2'b00, r_inflight};
      if (r_state == ST_RUN) begin
         w_issue = (w_level < 3'd2);
      end else begin
         w_issue = 1'b0;
      end
   end

   assign w_abort  = !enable && ((r_state == ST_RUN) || (r_state == ST_DRAIN));
   assign ram_csb  = ~w_issue;
   assign ram_addr = r_addr;
   assign sample_o = r_buf0;
   assign valid_o  = (r_count != 2'd0);
   assign busy_o   = r_busy;
   assign done_o   = r_done;

   // Pass sequencer: window walk, read-in-flight tracking and status flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_end      <= '0;
`ifdef WFG_STREAMER_LOOP_EN
         r_start    <= '0;
`endif
         r_inflight <= 1'b0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_inflight <= 1'b0;
               if (enable) begin
                  r_addr  <= start_addr;
                  r_end   <= end_addr;
`ifdef WFG_STREAMER_LOOP_EN
                  r_start <= start_addr;
`endif
                  r_state <= ST_RUN;
                  r_busy  <= 1'b1;
                  r_done  <= 1'b0;
               end
            end
            ST_RUN: begin
               if (!enable) begin
                  r_state    <= ST_IDLE;
                  r_inflight <= 1'b0;
                  r_busy     <= 1'b0;
               end else begin
                  r_inflight <= w_issue;
                  if (w_issue) begin
                     if (r_addr == r_end) begin
`ifdef WFG_STREAMER_LOOP_EN
                        r_addr  <= r_start;
`else
                        r_state <= ST_DRAIN;
`endif
                     end else begin
                        r_addr <= r_addr + ADDR_WIDTH'(1);
                     end
                  end
               end
            end
            ST_DRAIN: begin
               r_inflight <= 1'b0;
               if (!enable) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else if (!r_inflight && (r_count == 2'd0)) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
               end
            end
            ST_DONE: begin
               r_inflight <= 1'b0;
               if (!enable) begin
                  r_state <= ST_IDLE;
                  r_done  <= 1'b0;
               end
            end
            default: begin
               r_state    <= ST_IDLE;
               r_inflight <= 1'b0;
               r_busy     <= 1'b0;
               r_done     <= 1'b0;
            end
         endcase
      end
   end

   // Two-entry output buffer; r_buf0 is always the head presented downstream
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= 2'd0;
         r_buf0  <= '0;
         r_buf1  <= '0;
      end else if (w_abort) begin
         r_count <= 2'd0;
      end else begin
         case ({r_inflight, w_pop})
            2'b10: begin
               if (r_count == 2'd0) begin
                  r_buf0 <= ram_dout;
               end else begin
                  r_buf1 <= ram_dout;
               end
               r_count <= r_count + 2'd1;
            end
            2'b01: begin
               r_buf0  <= r_buf1;
               r_count <= r_count - 2'd1;
            end
            2'b11: begin
               if (r_count == 2'd1) begin
                  r_buf0 <= ram_dout;
               end else begin
                  r_buf0 <= r_buf1;
                  r_buf1 <= ram_dout;
               end
            end
            default: begin
               r_count <= r_count;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wfg_sample_streamer.sv
// Bench for wfg_sample_streamer: RAM model plus a window/sequence reference model.
module tb_wfg_sample_streamer;
   localparam int DW = 32;
   localparam int AW = 6;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          enable = 1'b0;
   logic          ready_i = 1'b0;
   logic [AW-1:0] start_addr = '0;
   logic [AW-1:0] end_addr = '0;
   logic [AW-1:0] ram_addr;
   logic          ram_csb;
   logic          valid_o;
   logic          busy_o;
   logic          done_o;
   logic [DW-1:0] ram_dout = '0;
   logic [DW-1:0] ram_q = '0;
   logic [DW-1:0] sample_o;
   logic [DW-1:0] mem [64];

   int n_vec = 0;
   int n_err = 0;

   wfg_sample_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable     (enable),
      .start_addr (start_addr),
      .end_addr   (end_addr),
      .ram_csb    (ram_csb),
      .ram_addr   (ram_addr),
      .ram_dout   (ram_dout),
      .sample_o   (sample_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .busy_o     (busy_o),
      .done_o     (done_o)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: address captured at the edge, data appears after the falling edge
   always @(posedge clk) if (!ram_csb) ram_q <= mem[ram_addr];
   always @(negedge clk) ram_dout <= ram_q;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_csb"},    32'(ram_csb),  32'd1);
      check({tag, "_addr"},   32'(ram_addr), 32'd0);
      check({tag, "_sample"}, sample_o,      32'd0);
      check({tag, "_valid"},  32'(valid_o),  32'd0);
      check({tag, "_busy"},   32'(busy_o),   32'd0);
      check({tag, "_done"},   32'(done_o),   32'd0);
   endtask

   // One pass: mode 0 ready=1, mode 1 ready pattern 1,0,0, mode 2 random ready; abort_at<0 means run to done
   task automatic run_pass(input int s, input int e, input int mode, input int abort_at);
      int n = ((e - s + 64) % 64) + 1;
      int k = 0;
      int issues = 0;
      int outst = 0;
      int c = 0;
      int first_v = -1;
      int last_pop = -1;
      bit fin = 1'b0;
      bit pop;
      bit prev_hold = 1'b0;
      logic [DW-1:0] prev_s = '0;
      @(negedge clk);
      start_addr = AW'(s);
      end_addr   = AW'(e);
      enable     = 1'b1;
      ready_i    = 1'b0;
      while (!fin) begin
         @(negedge clk);
         c++;
         if (prev_hold) begin
            check("hold_valid", 32'(valid_o), 32'd1);
            check("hold_data", sample_o, prev_s);
         end
         if (valid_o && first_v < 0) begin
            first_v = c;
            check("first_valid_latency", c, 32'd3);
         end
         if (c == 1) check("busy_in_run", 32'(busy_o), 32'd1);
         if (done_o) begin
            check("done_sample_count", k, n);
            check("done_issue_count", issues, n);
            check("done_busy", 32'(busy_o), 32'd0);
            check("done_valid", 32'(valid_o), 32'd0);
            if (mode == 0) check("no_gap_last_pop", last_pop, n + 2);
            @(negedge clk);
            check("done_held", 32'(done_o), 32'd1);
            enable = 1'b0;
            @(negedge clk);
            check("done_cleared", 32'(done_o), 32'd0);
            fin = 1'b1;
         end else if (c == abort_at) begin
            if (mode == 0) check("no_gap_pops", k, c - 3);
            enable = 1'b0;
            @(negedge clk);
            check("abort_valid", 32'(valid_o), 32'd0);
            check("abort_busy", 32'(busy_o), 32'd0);
            check("abort_done", 32'(done_o), 32'd0);
            @(negedge clk);
            check("abort_no_done", 32'(done_o), 32'd0);
            fin = 1'b1;
         end else if (c > 400) begin
            check("pass_timeout", c, 32'd400);
            enable = 1'b0;
            fin = 1'b1;
         end else begin
            case (mode)
               0: ready_i = 1'b1;
               1: ready_i = (c % 3 == 0);
               default: ready_i = 1'($urandom_range(0, 1));
            endcase
            #1;
            pop = valid_o & ready_i;
            if (!ram_csb) begin
               check("csb_buffer_limit", 32'((outst - int'(pop)) < 2), 32'd1);
               issues++;
            end
            if (pop) begin
               check("sample", sample_o, mem[(s + k % n) % 64]);
               k++;
               last_pop = c;
            end
            outst += int'(!ram_csb) - int'(pop);
            prev_hold = valid_o & ~ready_i;
            prev_s    = sample_o;
         end
      end
   endtask

   initial begin
      for (int i = 0; i < 64; i++) mem[i] = 32'(i) * 32'h01010101;
      #1;
      check_reset_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

`ifdef WFG_STREAMER_LOOP_EN
      run_pass(0, 2, 0, 45);
      run_pass(10, 12, 0, 3);
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      run_pass(60, 5, 2, 80);
      run_pass(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 1, 90);
`else
      run_pass(4, 7, 0, -1);
      run_pass(62, 1, 0, -1);
      run_pass(0, 15, 1, -1);
      run_pass(0, 63, 0, 3);
      run_pass(10, int'($urandom_range(10, 30)), 0, -1);
      run_pass(33, 33, 0, -1);
      for (int i = 0; i < 64; i++) mem[i] = $urandom;
      for (int j = 0; j < 4; j++)
         run_pass(int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 2, -1);
`endif

      // Asynchronous reset in the middle of a pass, away from any clock edge
      @(negedge clk);
      start_addr = AW'(20);
      end_addr   = AW'(40);
      ready_i    = 1'b1;
      enable     = 1'b1;
      repeat (5) @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("mid_reset");
      enable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
`ifdef WFG_STREAMER_LOOP_EN
      run_pass(7, 9, 0, 20);
`else
      run_pass(7, 12, 0, -1);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
